// File: rtl/vga_sync_monitor.sv
// Watches a sampled VGA sync/pixel stream, measures line and frame geometry against
// the expected timing, locks after two clean frames and captures one probe pixel per frame.
module vga_sync_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480
) (
  input  logic        ClkPort,
  input  logic        Reset_n,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        bright,
  input  logic [11:0] rgb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  input  logic        err_clr,
  output logic        locked,
  output logic        sync_err,
  output logic [11:0] probe_rgb,
  output logic        probe_valid,
  output logic [15:0] frame_count,
  output logic [9:0]  h_total_meas,
  output logic [9:0]  v_total_meas
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [9:0] HT  = 10'(H_TOTAL);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] VT  = 10'(V_TOTAL);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] SAT = 10'h3FF;

  state_t      state, state_next;
  logic [1:0]  good_cnt, good_next;
  logic        prev_h, prev_v;
  logic [9:0]  hcnt, ax, vcnt, ay;
  logic        frame_err, probe_done;
  logic        line_start, frame_start, line_active, line_bad, frame_bad;
  logic        probe_hit, sync_set;
  logic [9:0]  h_len, v_len, ay_end;

  // A line that closes on the same sample as a frame start still belongs to the old frame,
  // so v_len/ay_end fold it in before the frame is judged.
  always_comb begin
    line_start  = pix_en & ~hSync & prev_h;
    frame_start = pix_en & ~vSync & prev_v;
    h_len       = (hcnt == SAT) ? SAT : hcnt + 10'd1;
    line_active = (ax != 10'd0);
    line_bad    = (h_len != HT) | (line_active & (ax != HA));
    v_len       = (line_start && vcnt != SAT) ? vcnt + 10'd1 : vcnt;
    ay_end      = (line_start && line_active && ay != SAT) ? ay + 10'd1 : ay;
    frame_bad   = (v_len != VT) | (ay_end != VA) | frame_err | (line_start & line_bad);
    probe_hit   = pix_en & bright & ~probe_done & (ax == probe_x) & (ay == probe_y);
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_h       <= 1'b1;
      prev_v       <= 1'b1;
      hcnt         <= '0;
      ax           <= '0;
      vcnt         <= '0;
      ay           <= '0;
      frame_err    <= 1'b0;
      frame_count  <= '0;
      h_total_meas <= '0;
      v_total_meas <= '0;
    end else if (pix_en) begin
      prev_h <= hSync;
      prev_v <= vSync;
      if (line_start) begin
        hcnt         <= '0;
        ax           <= {9'd0, bright};
        h_total_meas <= h_len;
      end else begin
        if (hcnt != SAT) hcnt <= hcnt + 10'd1;
        if (bright && ax != SAT) ax <= ax + 10'd1;
      end
      if (frame_start) begin
        vcnt         <= '0;
        ay           <= '0;
        frame_err    <= 1'b0;
        v_total_meas <= v_len;
        frame_count  <= frame_count + 16'd1;
      end else if (line_start) begin
        vcnt      <= v_len;
        ay        <= ay_end;
        frame_err <= frame_err | line_bad;
      end
    end
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
      probe_done  <= 1'b0;
    end else begin
      probe_valid <= probe_hit;
      if (probe_hit) probe_rgb <= rgb;
      if (frame_start)  probe_done <= 1'b0;
      else if (probe_hit) probe_done <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    sync_set   = 1'b0;
    if (frame_start) begin
      case (state)
        SEARCH: begin
          state_next = MEASURE;
          good_next  = 2'd0;
        end
        MEASURE: begin
          if (frame_bad) begin
            good_next = 2'd0;
          end else begin
            good_next = good_cnt + 2'd1;
            if (good_cnt + 2'd1 == 2'd2) state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_bad) begin
            state_next = MEASURE;
            good_next  = 2'd0;
            sync_set   = 1'b1;
          end
        end
        default: begin
          state_next = SEARCH;
          good_next  = 2'd0;
        end
      endcase
    end
  end

  // A new mismatch overrides a simultaneous clear request.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      locked   <= (state_next == LOCKED);
      sync_err <= sync_set | (sync_err & ~err_clr);
    end
  end

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameters SHALL be H_TOTAL (default 800), pixel clocks per line; H_ACTIVE (640), bright pixels per active line; V_TOTAL (525), lines per frame; V_ACTIVE (480), active lines per frame.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 ClkPort  in  1  system clock.
REQ-004 Reset_n  in  1  asynchronous active-low reset.
REQ-005 pix_en  in  1  one-cycle pixel strobe; all VGA inputs are sampled only on cycles with pix_en=1 ("samples").
REQ-006 hSync  in  1  horizontal sync, active-low.
REQ-007 vSync  in  1  vertical sync, active-low.
REQ-008 bright  in  1  active-video flag.
REQ-009 rgb  in  12  pixel colour {R[3:0],G[3:0],B[3:0]}.
REQ-010 probe_x, probe_y  in  10 each  active-area coordinate to capture.
REQ-011 err_clr  in  1  clears sync_err.
REQ-012 locked  out  1  timing matches parameters.
REQ-013 sync_err  out  1  sticky mismatch-while-locked flag.
REQ-014 probe_rgb  out  12  last captured probe pixel.
REQ-015 probe_valid  out  1  one-cycle capture strobe.
REQ-016 frame_count  out  16  frame starts seen, wraps 0xFFFF->0.
REQ-017 h_total_meas, v_total_meas  out  10 each  last measured line length and frame height.

Function
REQ-018 A line start SHALL be a sample where hSync=0 and the previous sample's hSync=1; a frame start SHALL be the same rule on vSync.
REQ-019 hcnt SHALL clear to 0 on a line start and otherwise increment per sample, saturating at 1023; at each line start, h_len = hcnt+1 (saturating) is loaded into h_total_meas.
REQ-020 ax SHALL count bright samples since line start; at line start, the completed line is "active" if ax>0.
REQ-021 A line mismatch SHALL be flagged if h_len != H_TOTAL, or if the line is active and ax != H_ACTIVE.
REQ-022 vcnt SHALL count line starts since frame start, saturating at 1023; ay SHALL count active lines completed in the frame; at frame start, vcnt goes to v_total_meas and both clear.
REQ-023 A frame mismatch SHALL be flagged if vcnt != V_TOTAL, ay != V_ACTIVE, or any line mismatch occurred in the frame.
REQ-024 If line and frame starts occur on the same sample, the line SHALL be closed first and counted in vcnt.
REQ-025 Probe: on a sample with bright=1, ax==probe_x and ay==probe_y, probe_rgb SHALL load rgb and probe_valid SHALL pulse high for exactly one ClkPort cycle on the following cycle; there is at most one capture per frame.
REQ-026 The FSM SHALL have states SEARCH, MEASURE, LOCKED; reset goes to SEARCH.
REQ-027 SEARCH->MEASURE on the first frame start; this partial frame is never judged and good_cnt is set to 0.
REQ-028 MEASURE, at frame start: clean frame increments good_cnt, and good_cnt reaching 2 goes to LOCKED; a mismatch sets good_cnt to 0 and stays in MEASURE.
REQ-029 LOCKED, at frame start: a mismatch goes to MEASURE with good_cnt=0 and sets sync_err.
REQ-030 locked SHALL be 1 exactly while in LOCKED (registered, one cycle after the transition sample).
REQ-031 err_clr clears sync_err; a simultaneous set SHALL win.
REQ-032 frame_count SHALL increment on every frame start, in all states.
REQ-033 With pix_en=0, all counters and state SHALL hold.

Reset
REQ-034 While Reset_n=0, all outputs SHALL be 0, all counters and good_cnt 0, FSM SEARCH, and previous-sync registers 1; a partial frame in progress at reset is discarded.
REQ-035 After reset release, the first sample SHALL never be treated as an edge unless sync was high beforehand.

Verification
REQ-036 Nominal 800x525 timing (640x480 bright) at pix_en every 4th cycle, 3 vSync falls -> locked=1 one cycle after the 3rd fall, frame_count=3, h_total_meas=800, v_total_meas=525.
REQ-037 probe_x=5, probe_y=2, rgb=0xA5C at that pixel -> probe_rgb=0xA5C, a single probe_valid pulse per frame.
REQ-038 While locked, a 524-line frame -> locked=0 and sync_err=1 at the next frame start, v_total_meas=524; two clean frames -> locked=1, sync_err stays 1.
REQ-039 err_clr=1 on the same cycle as a locked mismatch -> sync_err=1; err_clr alone later -> 0.
REQ-040 hSync held high 1100 samples -> hcnt saturates, h_total_meas=1023, frame flagged mismatch.
REQ-041 Reset_n pulsed low mid-line while locked -> all outputs 0 immediately, SEARCH; relock takes 3 frame starts.
